channel_fifo: RTL and testbench
===============================

// Module: channel_fifo
// PURPOSE
//   Parametrised valid/ready channel buffer; successor to the single-stage channel.
//   Holds up to DEPTH words and sustains one transfer per clock in each direction.
//   Adds synchronous reset, fill level and almost-full flag.
//   Drops in between any producer/consumer pair that uses the in_*/out_* handshake.
// PARAMETERS
//   WIDTH  8  data word width in bits, >= 1
//   DEPTH  4  storage words, power of two, >= 2
//   AFULL  3  almost_full asserts when count >= AFULL, 1..DEPTH
// PORTS
//   clk          in   1                  single clock, all logic on posedge
//   rst          in   1                  synchronous reset, active-high
//   in_dat       in   WIDTH              write data
//   in_val       in   1                  producer offers in_dat
//   in_rdy       out  1                  FIFO accepts in_dat this cycle
//   out_dat      out  WIDTH              head-of-queue data
//   out_val      out  1                  out_dat valid
//   out_rdy      in   1                  consumer takes out_dat this cycle
//   count        out  $clog2(DEPTH+1)    words currently stored
//   almost_full  out  1                  count >= AFULL
// BEHAVIOUR
//   - Reset: one clock, synchronous, active-high. rst sampled high at posedge ->
//     wr_ptr=0, rd_ptr=0, count=0. While rst is high, in_rdy=0 and out_val=0 and
//     no push/pop happens. Cycle after rst drops: in_rdy=1, out_val=0,
//     almost_full=0. Storage array is not reset.
//   - Reset mid-operation discards all stored words; nothing in flight is output.
//   - push = in_val & in_rdy; pop = out_val & out_rdy. Transfers happen only at
//     posedge where the respective product is 1.
//   - in_rdy  = !rst & (count != DEPTH). Combinational from registered state only;
//     in_rdy never depends on out_rdy (no pass-through when full).
//   - out_val = !rst & (count != 0). Never depends on in_val (no bypass when empty).
//   - out_dat = mem[rd_ptr]; stable while out_val=1 and out_rdy=0. Don't-care
//     while out_val=0.
//   - Latency: word pushed at edge N is visible on out_dat/out_val after edge N
//     (first cycle it can be popped is N+1). Throughput 1 word/cycle sustained.
//   - Push: mem[wr_ptr] <= in_dat; wr_ptr <= wr_ptr+1.
//     Pop: rd_ptr <= rd_ptr+1.
//     Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
//   - count: push only +1; pop only -1; both or neither unchanged.
//     Never exceeds DEPTH, never underflows.
//   - Simultaneous push+pop: legal at any 0<count<DEPTH. At count=0 only push is
//     possible; at count=DEPTH only pop is possible.
//   - in_val with in_rdy=0: ignored, no state change. Producer must hold data.
//   - out_rdy with out_val=0: ignored.
//   - almost_full is registered-equivalent: a pure function of count.
//   - Ordering strictly FIFO; no word lost, duplicated or reordered.
// TESTING (WIDTH=8, DEPTH=4, AFULL=3 unless stated)
//   1 Reset: rst=1 two cycles, then 0
//     -> in_rdy=0/out_val=0 during rst; after: in_rdy=1, out_val=0, count=0.
//   2 Fill: out_rdy=0, push 0x01..0x05 back-to-back
//     -> 0x01..0x04 accepted; count 1,2,3,4; almost_full from count=3;
//        in_rdy=0 at count=4; 0x05 held.
//   3 Drain: from full, out_rdy=1, in_val=0
//     -> out_dat 0x01,0x02,0x03,0x04 on 4 consecutive cycles; then out_val=0, count=0.
//   4 Streaming: in_val=1 and out_rdy=1 continuously for 20 cycles, incrementing data
//     -> after first word, one word out per cycle; count stays 1; order preserved
//        across pointer wrap.
//   5 Full + pop: count=4, in_val=1, out_rdy=1
//     -> only the pop occurs (in_rdy=0); count=3 next cycle; push accepted the cycle after.
//   6 Mid-op reset: count=2, assert rst one cycle
//     -> count=0, out_val=0; next push 0xAA is the next word out.
//      Random valid/ready toggling: 1000 words against a scoreboard, no mismatch.

Source files
------------

// File: rtl/channel_fifo.sv
// Valid/ready channel buffer holding up to DEPTH words, one transfer per clock
// in each direction, with fill level and almost-full flag.
module channel_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AFULL = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_dat,
  input  logic                       in_val,
  output logic                       in_rdy,
  output logic [WIDTH-1:0]           out_dat,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  // Handshake flags come from registered state only, so no in->out combinational path.
  assign in_rdy      = !rst && (count_q != CW'(DEPTH));
  assign out_val     = !rst && (count_q != '0);
  assign push        = in_val && in_rdy;
  assign pop         = out_val && out_rdy;
  assign out_dat     = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = (count_q >= CW'(AFULL));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; push is already gated by reset through in_rdy.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_dat;
  end

endmodule

// File: tb/tb_channel_fifo.sv
// Directed and randomized checks of channel_fifo (WIDTH=8, DEPTH=4, AFULL=3).
module tb_channel_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_dat = '0;
  logic       in_val = 1'b0;
  logic       in_rdy;
  logic [7:0] out_dat;
  logic       out_val;
  logic       out_rdy = 1'b0;
  logic [2:0] count;
  logic       almost_full;

  int errors = 0;
  int checks = 0;

  channel_fifo #(.WIDTH(8), .DEPTH(4), .AFULL(3)) dut (
    .clk(clk), .rst(rst), .in_dat(in_dat), .in_val(in_val), .in_rdy(in_rdy),
    .out_dat(out_dat), .out_val(out_val), .out_rdy(out_rdy),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_val = 1'b1; in_dat = 8'hEE; out_rdy = 1'b1;
    #1;
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL reset_in_rdy: got %b want 0", in_rdy); end
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val: got %b want 0", out_val); end
    @(negedge clk);
    #1;
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL reset2_in_rdy: got %b want 0", in_rdy); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset2_count: got %0d want 0", count); end
    @(negedge clk);
    rst = 1'b0; in_val = 1'b0; out_rdy = 1'b0;
    #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_in_rdy: got %b want 1", in_rdy); end
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL post_reset_out_val: got %b want 0", out_val); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL post_reset_count: got %0d want 0", count); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL post_reset_afull: got %b want 0", almost_full); end
  endtask

  task automatic test_fill();
    int exp_cnt;
    out_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      in_val = 1'b1; in_dat = 8'(i);
      #1;
      exp_cnt = (i - 1 > 4) ? 4 : i - 1;
      checks++; if (count !== 3'(exp_cnt)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, exp_cnt); end
      checks++; if (almost_full !== (exp_cnt >= 3)) begin errors++; $display("FAIL fill_afull[%0d]: got %b want %b", i, almost_full, exp_cnt >= 3); end
      checks++; if (in_rdy !== (exp_cnt != 4)) begin errors++; $display("FAIL fill_in_rdy[%0d]: got %b want %b", i, in_rdy, exp_cnt != 4); end
    end
    @(negedge clk);
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_held_count: got %0d want 4", count); end
    checks++; if (out_dat !== 8'h01) begin errors++; $display("FAIL fill_head: got %h want 01", out_dat); end
    in_val = 1'b0;
  endtask

  task automatic test_drain();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_val = 1'b0; out_rdy = 1'b1;
      #1;
      checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL drain_val[%0d]: got %b want 1", k, out_val); end
      checks++; if (out_dat !== 8'(k + 1)) begin errors++; $display("FAIL drain_dat[%0d]: got %h want %h", k, out_dat, 8'(k + 1)); end
      checks++; if (count !== 3'(4 - k)) begin errors++; $display("FAIL drain_count[%0d]: got %0d want %0d", k, count, 4 - k); end
    end
    @(negedge clk);
    out_rdy = 1'b0;
    #1;
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL drain_empty_val: got %b want 0", out_val); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_empty_count: got %0d want 0", count); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL drain_empty_in_rdy: got %b want 1", in_rdy); end
  endtask

  task automatic test_streaming();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_val = 1'b1; in_dat = 8'(8'h10 + c); out_rdy = 1'b1;
      #1;
      if (c == 0) begin
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL stream_first_val: got %b want 0", out_val); end
      end else begin
        checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL stream_val[%0d]: got %b want 1", c, out_val); end
        checks++; if (out_dat !== 8'(8'h10 + c - 1)) begin errors++; $display("FAIL stream_dat[%0d]: got %h want %h", c, out_dat, 8'(8'h10 + c - 1)); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d]: got %0d want 1", c, count); end
      end
    end
    @(negedge clk);
    in_val = 1'b0; out_rdy = 1'b1;
    #1;
    checks++; if (out_dat !== 8'h23) begin errors++; $display("FAIL stream_last_dat: got %h want 23", out_dat); end
    @(negedge clk);
    out_rdy = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_end_count: got %0d want 0", count); end
  endtask

  task automatic test_full_pop();
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_val = 1'b1; in_dat = 8'(8'h31 + i);
    end
    @(negedge clk);
    in_val = 1'b1; in_dat = 8'h35; out_rdy = 1'b1;
    #1;
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL fullpop_in_rdy: got %b want 0", in_rdy); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpop_count: got %0d want 4", count); end
    checks++; if (out_dat !== 8'h31) begin errors++; $display("FAIL fullpop_head: got %h want 31", out_dat); end
    @(negedge clk);
    out_rdy = 1'b0;
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fullpop_count_after: got %0d want 3", count); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL fullpop_in_rdy_after: got %b want 1", in_rdy); end
    checks++; if (out_dat !== 8'h32) begin errors++; $display("FAIL fullpop_head_after: got %h want 32", out_dat); end
    @(negedge clk);
    in_val = 1'b0;
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpop_refill: got %0d want 4", count); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      out_rdy = 1'b1;
      #1;
      checks++; if (out_dat !== 8'(8'h32 + k)) begin errors++; $display("FAIL fullpop_drain[%0d]: got %h want %h", k, out_dat, 8'(8'h32 + k)); end
    end
    @(negedge clk);
    out_rdy = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL fullpop_end_count: got %0d want 0", count); end
  endtask

  task automatic test_midop_reset();
    out_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_val = 1'b1; in_dat = 8'(8'h41 + i);
    end
    @(negedge clk);
    in_val = 1'b0;
    #1;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL midrst_pre_count: got %0d want 2", count); end
    @(negedge clk);
    rst = 1'b1; in_val = 1'b1; in_dat = 8'h99; out_rdy = 1'b1;
    #1;
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL midrst_out_val: got %b want 0", out_val); end
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL midrst_in_rdy: got %b want 0", in_rdy); end
    @(negedge clk);
    rst = 1'b0; in_val = 1'b1; in_dat = 8'hAA; out_rdy = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", count); end
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL midrst_post_val: got %b want 0", out_val); end
    @(negedge clk);
    in_val = 1'b0;
    #1;
    checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL midrst_aa_val: got %b want 1", out_val); end
    checks++; if (out_dat !== 8'hAA) begin errors++; $display("FAIL midrst_aa_dat: got %h want aa", out_dat); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL midrst_aa_count: got %0d want 1", count); end
    @(negedge clk);
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL midrst_end_count: got %0d want 0", count); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic       pend;
    int         sent, recv, cyc;
    bit         exp_in_rdy, exp_out_val;
    pend = 1'b0; sent = 0; recv = 0; cyc = 0;
    while (recv < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (!pend && ($urandom_range(0, 3) != 0)) begin
        pend = 1'b1;
        in_dat = 8'(sent * 7 + 3);
        sent++;
      end
      in_val  = pend;
      out_rdy = ($urandom_range(0, 2) != 0);
      #1;
      exp_in_rdy  = (q.size() < 4);
      exp_out_val = (q.size() != 0);
      checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", cyc, count, q.size()); end
      checks++; if (in_rdy !== exp_in_rdy) begin errors++; $display("FAIL rand_in_rdy[%0d]: got %b want %b", cyc, in_rdy, exp_in_rdy); end
      checks++; if (out_val !== exp_out_val) begin errors++; $display("FAIL rand_out_val[%0d]: got %b want %b", cyc, out_val, exp_out_val); end
      if (exp_out_val) begin
        checks++; if (out_dat !== q[0]) begin errors++; $display("FAIL rand_dat[%0d]: got %h want %h", recv, out_dat, q[0]); end
        if (out_rdy) begin
          void'(q.pop_front());
          recv++;
        end
      end
      if (pend && exp_in_rdy) begin
        q.push_back(in_dat);
        pend = 1'b0;
      end
    end
    checks++;
    if (recv < 1000) begin errors++; $display("FAIL rand_timeout: got %0d words want 1000", recv); end
    @(negedge clk);
    in_val = 1'b0; out_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_streaming();
    test_full_pop();
    test_midop_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
